// File: rtl/lcl_err_collector.sv
// rtl/lcl_err_collector.sv - collects per-line error pulses and reports them round-robin over a valid/ready handshake
module lcl_err_collector #(
    parameter int LCL  = 4,
    parameter int INW  = 2,
    parameter int CNTW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [LCL-1:0]  lcl_err,
    input  logic            clr,
    input  logic            err_ready,
    output logic            err_valid,
    output logic [INW-1:0]  err_idx,
    output logic            err_drop,
    output logic [CNTW-1:0] err_cnt
);

    typedef enum logic {IDLE, VALID} state_t;

    state_t          state, state_next;
    logic [LCL-1:0]  pending, pending_next;
    logic [INW-1:0]  ptr, ptr_next;
    logic [INW-1:0]  idx_next;
    logic            drop_next;
    logic [CNTW-1:0] cnt_next;
    logic [LCL-1:0]  acc_mask;
    logic [LCL-1:0]  others;
    logic            accept;

    // First requesting line at or above base, wrapping at LCL-1; always < LCL.
    function automatic logic [INW-1:0] rr_pick(input logic [LCL-1:0] req,
                                               input logic [INW-1:0] base);
        logic [INW-1:0] pick;
        logic           found;
        int             j;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < LCL; k++) begin
            j = (int'(base) + k) % LCL;
            if (!found && req[j]) begin
                pick  = INW'(j);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign err_valid = (state == VALID);
    assign accept    = err_valid & err_ready;

    always_comb begin
        acc_mask = '0;
        for (int i = 0; i < LCL; i++) begin
            acc_mask[i] = accept && (int'(err_idx) == i);
        end
    end

    assign others = pending & ~acc_mask;

    always_comb begin
        state_next   = state;
        pending_next = others | lcl_err;
        ptr_next     = ptr;
        idx_next     = err_idx;
        drop_next    = err_drop | (|(lcl_err & pending & ~acc_mask));
        cnt_next     = err_cnt;

        case (state)
            IDLE: begin
                if (|pending) begin
                    state_next = VALID;
                    idx_next   = rr_pick(pending, ptr);
                end
            end
            VALID: begin
                if (err_ready) begin
                    ptr_next = INW'((int'(err_idx) + 1) % LCL);
                    if (cnt_next != {CNTW{1'b1}}) begin
                        cnt_next = cnt_next + 1'b1;
                    end
                    // Only lines already pending keep VALID; fresh pulses wait for the next search.
                    if (|others) begin
                        idx_next = rr_pick(others, ptr_next);
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (clr) begin
            state_next   = IDLE;
            pending_next = '0;
            ptr_next     = '0;
            idx_next     = '0;
            drop_next    = 1'b0;
            cnt_next     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pending  <= '0;
            ptr      <= '0;
            err_idx  <= '0;
            err_drop <= 1'b0;
            err_cnt  <= '0;
        end else begin
            state    <= state_next;
            pending  <= pending_next;
            ptr      <= ptr_next;
            err_idx  <= idx_next;
            err_drop <= drop_next;
            err_cnt  <= cnt_next;
        end
    end

endmodule

// File: tb/tb_lcl_err_collector.sv
// tb/tb_lcl_err_collector.sv - directed self-checking bench for lcl_err_collector
module tb_lcl_err_collector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] lcl_err;
    logic       clr;
    logic       err_ready;
    logic       err_valid;
    logic [1:0] err_idx;
    logic       err_drop;
    logic [3:0] err_cnt;

    int checks = 0;
    int errors = 0;

    lcl_err_collector #(.LCL(4), .INW(2), .CNTW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lcl_err   (lcl_err),
        .clr       (clr),
        .err_ready (err_ready),
        .err_valid (err_valid),
        .err_idx   (err_idx),
        .err_drop  (err_drop),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; lcl_err = '0; clr = 1'b0; err_ready = 1'b0;
        tick(); tick();
        check("rst_valid", err_valid, 0);
        check("rst_idx", err_idx, 0);
        check("rst_drop", err_drop, 0);
        check("rst_cnt", err_cnt, 0);
        rst_n = 1'b1;

        // single event on line 2
        err_ready = 1'b1;
        lcl_err = 4'b0100; tick();
        lcl_err = 4'b0000;
        check("s1_latency", err_valid, 0);
        tick();
        check("s1_valid", err_valid, 1);
        check("s1_idx", err_idx, 2);
        tick();
        check("s1_idle", err_valid, 0);
        check("s1_cnt", err_cnt, 1);
        check("s1_drop", err_drop, 0);

        // back-to-back round robin from ptr 0
        do_clr();
        check("s2_clr_cnt", err_cnt, 0);
        lcl_err = 4'b1011; tick();
        lcl_err = 4'b0000; tick();
        check("s2_v0", err_valid, 1);
        check("s2_i0", err_idx, 0);
        tick();
        check("s2_v1", err_valid, 1);
        check("s2_i1", err_idx, 1);
        tick();
        check("s2_v3", err_valid, 1);
        check("s2_i3", err_idx, 3);
        tick();
        check("s2_idle", err_valid, 0);
        check("s2_cnt", err_cnt, 3);

        // backpressure and drop
        do_clr();
        err_ready = 1'b0;
        lcl_err = 4'b0010; tick();
        lcl_err = 4'b0000; tick();
        check("s3_valid", err_valid, 1);
        check("s3_idx", err_idx, 1);
        check("s3_nodrop", err_drop, 0);
        lcl_err = 4'b0010; tick();
        lcl_err = 4'b0000;
        check("s3_drop", err_drop, 1);
        check("s3_hold_v", err_valid, 1);
        check("s3_hold_i", err_idx, 1);
        check("s3_cnt0", err_cnt, 0);
        err_ready = 1'b1; tick();
        check("s3_acc_idle", err_valid, 0);
        check("s3_cnt1", err_cnt, 1);
        tick();
        check("s3_cnt_once", err_cnt, 1);
        check("s3_drop_sticky", err_drop, 1);

        // re-pulse in accept cycle, then saturation
        do_clr();
        check("s4_drop_clr", err_drop, 0);
        lcl_err = 4'b1000; tick();
        lcl_err = 4'b0000; tick();
        check("s4_idx3", err_idx, 3);
        lcl_err = 4'b1000; tick();
        lcl_err = 4'b0000;
        check("s4_idle", err_valid, 0);
        check("s4_cnt1", err_cnt, 1);
        check("s4_nodrop", err_drop, 0);
        tick();
        check("s4_again_v", err_valid, 1);
        check("s4_again_i", err_idx, 3);
        tick();
        check("s4_cnt2", err_cnt, 2);
        for (int n = 0; n < 20; n++) begin
            lcl_err = 4'b0001; tick();
            lcl_err = 4'b0000; tick(); tick();
        end
        check("s4_sat", err_cnt, 15);

        // clr priority over pulse and acceptance
        do_clr();
        err_ready = 1'b0;
        lcl_err = 4'b0100; tick();
        lcl_err = 4'b0000; tick();
        check("s5_valid", err_valid, 1);
        check("s5_idx", err_idx, 2);
        clr = 1'b1; lcl_err = 4'b0001; err_ready = 1'b1; tick();
        clr = 1'b0; lcl_err = 4'b0000;
        check("s5_clr_idle", err_valid, 0);
        check("s5_clr_cnt", err_cnt, 0);
        tick(); tick();
        check("s5_quiet_v", err_valid, 0);
        check("s5_quiet_cnt", err_cnt, 0);

        // asynchronous reset mid-cycle while VALID
        err_ready = 1'b0;
        lcl_err = 4'b0100; tick();
        lcl_err = 4'b0000; tick();
        check("s6_valid", err_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("s6_async_v", err_valid, 0);
        check("s6_async_i", err_idx, 0);
        rst_n = 1'b1;
        lcl_err = 4'b0100; tick();
        lcl_err = 4'b0000; tick();
        check("s6_post_v", err_valid, 1);
        check("s6_post_i", err_idx, 2);
        check("s6_post_cnt", err_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
